// File: rtl/mando_vehiculo_pkg.sv
// Shared constants for the hybrid-drive command initiator: one-hot states,
// mode encoding, default timeouts and the engage decode helper.
package mando_pkg;

   typedef logic [4:0] estado_t;

   localparam estado_t ST_REPOSO = 5'b00001;
   localparam estado_t ST_ESPERA = 5'b00010;
   localparam estado_t ST_MARCHA = 5'b00100;
   localparam estado_t ST_FIN_OK = 5'b01000;
   localparam estado_t ST_FALLA  = 5'b10000;

   localparam logic MODO_GAS       = 1'b1;
   localparam logic MODO_ELECTRICO = 1'b0;

   localparam int W_DEF          = 8;
   localparam int T_ARRANQUE_DEF = 4;
   localparam int T_MARCHA_DEF   = 200;

   // True when exactly the motor belonging to 'modo' is on.
   function automatic logic motor_enganchado(input logic modo,
                                             input logic motor1,
                                             input logic motor2);
      if (modo == MODO_GAS)
         return motor2 && !motor1;
      else
         return motor1 && !motor2;
   endfunction

endpackage

// File: rtl/mando_vehiculo_if.sv
// Signal bundle between the operator/supervisor side, the command initiator
// and the drive controller's ARRANQUE/MODO -> MOTOR1/MOTOR2 lines.
interface mando_vehiculo_if #(
   parameter int W = 8
);
   // Handshake: PEDIDO is a request pulse taken once in REPOSO; ARRANQUE is the
   // initiator's "valid" to the controller, held until the selected motor alone
   // answers (the "ready"), at which point ARRANQUE drops on that same edge.
   logic         PEDIDO;
   logic         MODO_SEL;
   logic         MOTOR1;
   logic         MOTOR2;
   logic         ARRANQUE;
   logic         MODO;
   logic         OCUPADO;
   logic         LISTO;
   logic         FALLA;
   logic [W-1:0] CICLOS;
   logic [4:0]   ESTADO;
   logic [W-1:0] DBG_ESPERA;

   modport master (
      input  PEDIDO, MODO_SEL, MOTOR1, MOTOR2,
      output ARRANQUE, MODO, OCUPADO, LISTO, FALLA, CICLOS, ESTADO, DBG_ESPERA
   );

   modport slave (
      output PEDIDO, MODO_SEL, MOTOR1, MOTOR2,
      input  ARRANQUE, MODO, OCUPADO, LISTO, FALLA, CICLOS, ESTADO, DBG_ESPERA
   );

endinterface

// File: rtl/mando_vehiculo_contador_limite.sv
// Unsigned up-counter with synchronous clear, enable and an equality flag
// raised when the count equals LIMITE.
module contador_limite #(
   parameter int W      = 8,
   parameter int LIMITE = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cuenta,
   output logic         o_limite
);

   logic [W-1:0] r_cuenta;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cuenta <= '0;
      else if (i_clr)
         r_cuenta <= '0;
      else if (i_en)
         r_cuenta <= r_cuenta + W'(1);
   end

   assign o_cuenta = r_cuenta;
   assign o_limite = (r_cuenta == W'(LIMITE));

endmodule

// File: rtl/mando_vehiculo.sv
// Command initiator for the hybrid drive: start handshake, engage check and
// run-length measurement. Optional checks enabled by `define MANDO_CHEQUEO_EN.
module mando_vehiculo
   import mando_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int T_ARRANQUE = T_ARRANQUE_DEF,
   parameter int T_MARCHA   = T_MARCHA_DEF
) (
   input logic              CLK,
   input logic              REINICIO,
   mando_vehiculo_if.master bus
);

   localparam int WT = $clog2(T_ARRANQUE + 1);

   estado_t       r_estado;
   estado_t       w_estado_sig;
   logic          r_modo;

   logic          w_eng;
   logic          w_ambos;
   logic          w_ninguno;
   logic          w_erroneo;
   logic          w_legal;

   logic          w_clr;
   logic          w_en_t;
   logic          w_en_c;
   logic          w_lim_t;
   logic          w_lim_c;
   logic [WT-1:0] w_cuenta_t;
   logic [W-1:0]  w_ciclos;

   assign w_eng   = motor_enganchado(r_modo, bus.MOTOR1, bus.MOTOR2);
   assign w_ambos = bus.MOTOR1 && bus.MOTOR2;

`ifdef MANDO_CHEQUEO_EN
   assign w_ninguno = !bus.MOTOR1 && !bus.MOTOR2;
   // The motor of the other mode alone answering is a controller error.
   assign w_erroneo = motor_enganchado(~r_modo, bus.MOTOR1, bus.MOTOR2);
`else
   assign w_ninguno = 1'b0;
   assign w_erroneo = 1'b0;
`endif

   contador_limite #(
      .W      (WT),
      .LIMITE (T_ARRANQUE - 1)
   ) u_cnt_espera (
      .i_clk    (CLK),
      .i_rst    (REINICIO),
      .i_clr    (w_clr),
      .i_en     (w_en_t),
      .o_cuenta (w_cuenta_t),
      .o_limite (w_lim_t)
   );

   contador_limite #(
      .W      (W),
      .LIMITE (T_MARCHA - 1)
   ) u_cnt_ciclos (
      .i_clk    (CLK),
      .i_rst    (REINICIO),
      .i_clr    (w_clr),
      .i_en     (w_en_c),
      .o_cuenta (w_ciclos),
      .o_limite (w_lim_c)
   );

   always_comb begin
      w_estado_sig = r_estado;
      w_clr        = 1'b0;
      w_en_t       = 1'b0;
      w_en_c       = 1'b0;
      case (r_estado)
         ST_REPOSO: begin
            if (bus.PEDIDO) begin
               w_clr        = 1'b1;
               w_estado_sig = ST_ESPERA;
            end
         end
         ST_ESPERA: begin
            if (w_eng)
               w_estado_sig = ST_MARCHA;
            else if (w_erroneo)
               w_estado_sig = ST_FALLA;
            else if (w_lim_t)
               w_estado_sig = ST_FALLA;
            else
               w_en_t = 1'b1;
         end
         ST_MARCHA: begin
            if (w_ambos)
               w_estado_sig = ST_FIN_OK;
            else if (w_ninguno)
               w_estado_sig = ST_FALLA;
            else begin
               // The last increment lands CICLOS exactly on T_MARCHA.
               w_en_c = 1'b1;
               if (w_lim_c)
                  w_estado_sig = ST_FALLA;
            end
         end
         ST_FIN_OK: w_estado_sig = ST_FIN_OK;
         ST_FALLA:  w_estado_sig = ST_FALLA;
         default:   w_estado_sig = ST_REPOSO;
      endcase
   end

   always_ff @(posedge CLK or posedge REINICIO) begin
      if (REINICIO) begin
         r_estado <= ST_REPOSO;
         r_modo   <= MODO_ELECTRICO;
      end else begin
         r_estado <= w_estado_sig;
         if (w_clr)
            r_modo <= bus.MODO_SEL;
      end
   end

   assign w_legal = (r_estado == ST_REPOSO) || (r_estado == ST_ESPERA) ||
                    (r_estado == ST_MARCHA) || (r_estado == ST_FIN_OK) ||
                    (r_estado == ST_FALLA);

   assign bus.ARRANQUE   = (r_estado == ST_ESPERA);
   assign bus.MODO       = r_modo && ((r_estado == ST_ESPERA) || (r_estado == ST_MARCHA));
   assign bus.OCUPADO    = w_legal && (r_estado != ST_REPOSO);
   assign bus.LISTO      = (r_estado == ST_FIN_OK);
   assign bus.FALLA      = (r_estado == ST_FALLA);
   assign bus.CICLOS     = w_legal ? w_ciclos : '0;
   assign bus.ESTADO     = r_estado;
   assign bus.DBG_ESPERA = W'(w_cuenta_t);

   a_estado_onehot : assert property (@(posedge CLK) disable iff (REINICIO)
      $onehot(r_estado));

   a_ciclos_tope : assert property (@(posedge CLK) disable iff (REINICIO)
      w_ciclos <= W'(T_MARCHA));

endmodule

// File: tb/tb_mando_vehiculo.sv
// Directed bench for mando_vehiculo with default parameters; the protocol
// scenario follows whichever MANDO_CHEQUEO_EN build is compiled.
module tb_mando_vehiculo;
   import mando_pkg::*;

   logic CLK      = 1'b0;
   logic REINICIO = 1'b1;
   bit   clk_on   = 1'b1;
   int   n_pass   = 0;
   int   n_total  = 0;

   mando_vehiculo_if #(.W(8)) bus ();

   mando_vehiculo #(
      .W          (8),
      .T_ARRANQUE (4),
      .T_MARCHA   (200)
   ) dut (
      .CLK      (CLK),
      .REINICIO (REINICIO),
      .bus      (bus)
   );

   // Clock / reset block; clk_on lets a test freeze the clock low.
   always begin
      #5;
      if (clk_on) CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // Driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      REINICIO     = 1'b1;
      bus.PEDIDO   = 1'b0;
      bus.MODO_SEL = 1'b0;
      bus.MOTOR1   = 1'b0;
      bus.MOTOR2   = 1'b0;
      tick();
      tick();
      REINICIO = 1'b0;
   endtask

   task automatic pedir(input logic modo);
      bus.PEDIDO   = 1'b1;
      bus.MODO_SEL = modo;
      tick();
      bus.PEDIDO   = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] salidas;
      REINICIO = 1'b1;
      bus.PEDIDO = 1'b0; bus.MODO_SEL = 1'b0; bus.MOTOR1 = 1'b0; bus.MOTOR2 = 1'b0;
      tick();
      salidas = {bus.ARRANQUE, bus.MODO, bus.OCUPADO, bus.LISTO, bus.FALLA, bus.CICLOS};
      n_total++; if (salidas !== 13'd0) $display("FAIL reset_outputs: got %b want 0", salidas); else n_pass++;
      REINICIO = 1'b0;
      repeat (3) tick();
      n_total++; if (bus.OCUPADO !== 1'b0) $display("FAIL reset_idle_ocupado: got %b want 0", bus.OCUPADO); else n_pass++;
      n_total++; if (bus.ARRANQUE !== 1'b0) $display("FAIL reset_idle_arranque: got %b want 0", bus.ARRANQUE); else n_pass++;
   endtask

   task automatic test_electrico();
      logic [7:0] exp_q[$];
      logic [7:0] e;
      int n_arr;
      do_reset();
      pedir(MODO_ELECTRICO);
      n_total++; if (bus.OCUPADO !== 1'b1) $display("FAIL elec_ocupado: got %b want 1", bus.OCUPADO); else n_pass++;
      n_arr = 0;
      for (int i = 0; i < 2; i++) begin
         if (bus.ARRANQUE === 1'b1) n_arr++;
         if (i == 1) bus.MOTOR1 = 1'b1;
         tick();
      end
      n_total++; if (n_arr !== 2) $display("FAIL elec_arranque_len: got %0d want 2", n_arr); else n_pass++;
      n_total++; if (bus.ARRANQUE !== 1'b0) $display("FAIL elec_arranque_low: got %b want 0", bus.ARRANQUE); else n_pass++;
      for (int v = 0; v <= 10; v++) exp_q.push_back(8'(v));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_total++; if (bus.CICLOS !== e) $display("FAIL elec_ciclos: got %0d want %0d", bus.CICLOS, e); else n_pass++;
         if (exp_q.size() == 0) bus.MOTOR2 = 1'b1;
         tick();
      end
      n_total++; if (bus.LISTO !== 1'b1) $display("FAIL elec_listo: got %b want 1", bus.LISTO); else n_pass++;
      n_total++; if (bus.FALLA !== 1'b0) $display("FAIL elec_falla: got %b want 0", bus.FALLA); else n_pass++;
      n_total++; if (bus.CICLOS !== 8'd10) $display("FAIL elec_ciclos_fin: got %0d want 10", bus.CICLOS); else n_pass++;
      bus.PEDIDO = 1'b1;
      repeat (3) tick();
      bus.PEDIDO = 1'b0;
      n_total++; if (bus.LISTO !== 1'b1 || bus.ARRANQUE !== 1'b0) $display("FAIL elec_terminal: got listo=%b arranque=%b want 1/0", bus.LISTO, bus.ARRANQUE); else n_pass++;
      n_total++; if (bus.CICLOS !== 8'd10) $display("FAIL elec_ciclos_hold: got %0d want 10", bus.CICLOS); else n_pass++;
   endtask

   task automatic test_gas();
      do_reset();
      pedir(MODO_GAS);
      n_total++; if (bus.MODO !== 1'b1) $display("FAIL gas_modo: got %b want 1", bus.MODO); else n_pass++;
      bus.MOTOR2 = 1'b1;
      tick();
      n_total++; if (bus.ARRANQUE !== 1'b0 || bus.CICLOS !== 8'd0) $display("FAIL gas_marcha: got arranque=%b ciclos=%0d want 0/0", bus.ARRANQUE, bus.CICLOS); else n_pass++;
      repeat (199) tick();
      n_total++; if (bus.FALLA !== 1'b0 || bus.CICLOS !== 8'd199) $display("FAIL gas_pre_timeout: got falla=%b ciclos=%0d want 0/199", bus.FALLA, bus.CICLOS); else n_pass++;
      tick();
      n_total++; if (bus.FALLA !== 1'b1) $display("FAIL gas_falla: got %b want 1", bus.FALLA); else n_pass++;
      n_total++; if (bus.CICLOS !== 8'd200) $display("FAIL gas_ciclos: got %0d want 200", bus.CICLOS); else n_pass++;
      n_total++; if (bus.LISTO !== 1'b0) $display("FAIL gas_listo: got %b want 0", bus.LISTO); else n_pass++;
   endtask

   task automatic test_sin_arranque();
      int n_arr;
      do_reset();
      bus.PEDIDO   = 1'b1;
      bus.MODO_SEL = MODO_GAS;
      tick();
      bus.MODO_SEL = MODO_ELECTRICO;
      n_arr = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.ARRANQUE === 1'b1) n_arr++;
         if (i == 2) begin
            n_total++; if (bus.MODO !== 1'b1) $display("FAIL noeng_modo_latched: got %b want 1", bus.MODO); else n_pass++;
         end
         if (i == 3) begin
            n_total++; if (bus.FALLA !== 1'b0) $display("FAIL noeng_falla_early: got %b want 0", bus.FALLA); else n_pass++;
         end
         if (i == 4) begin
            n_total++; if (bus.FALLA !== 1'b1) $display("FAIL noeng_falla_edge: got %b want 1", bus.FALLA); else n_pass++;
         end
         tick();
      end
      bus.PEDIDO = 1'b0;
      n_total++; if (n_arr !== 4) $display("FAIL noeng_arranque_len: got %0d want 4", n_arr); else n_pass++;
      n_total++; if (bus.FALLA !== 1'b1 || bus.OCUPADO !== 1'b1) $display("FAIL noeng_terminal: got falla=%b ocupado=%b want 1/1", bus.FALLA, bus.OCUPADO); else n_pass++;
      n_total++; if (bus.CICLOS !== 8'd0) $display("FAIL noeng_ciclos: got %0d want 0", bus.CICLOS); else n_pass++;
   endtask

   task automatic test_protocolo();
      do_reset();
      pedir(MODO_ELECTRICO);
      bus.MOTOR1 = 1'b1;
      tick();
      repeat (5) tick();
      n_total++; if (bus.CICLOS !== 8'd5) $display("FAIL proto_ciclos5: got %0d want 5", bus.CICLOS); else n_pass++;
      bus.MOTOR1 = 1'b0;
      tick();
`ifdef MANDO_CHEQUEO_EN
      n_total++; if (bus.FALLA !== 1'b1 || bus.CICLOS !== 8'd5) $display("FAIL proto_check: got falla=%b ciclos=%0d want 1/5", bus.FALLA, bus.CICLOS); else n_pass++;
`else
      n_total++; if (bus.FALLA !== 1'b0 || bus.CICLOS !== 8'd6) $display("FAIL proto_nocheck: got falla=%b ciclos=%0d want 0/6", bus.FALLA, bus.CICLOS); else n_pass++;
      repeat (193) tick();
      n_total++; if (bus.FALLA !== 1'b0 || bus.CICLOS !== 8'd199) $display("FAIL proto_nocheck_199: got falla=%b ciclos=%0d want 0/199", bus.FALLA, bus.CICLOS); else n_pass++;
      tick();
      n_total++; if (bus.FALLA !== 1'b1 || bus.CICLOS !== 8'd200) $display("FAIL proto_nocheck_200: got falla=%b ciclos=%0d want 1/200", bus.FALLA, bus.CICLOS); else n_pass++;
`endif
      // Wrong motor alone during ESPERA.
      do_reset();
      pedir(MODO_GAS);
      bus.MOTOR1 = 1'b1;
      tick();
`ifdef MANDO_CHEQUEO_EN
      n_total++; if (bus.FALLA !== 1'b1 || bus.ARRANQUE !== 1'b0) $display("FAIL wrong_motor_check: got falla=%b arranque=%b want 1/0", bus.FALLA, bus.ARRANQUE); else n_pass++;
`else
      n_total++; if (bus.FALLA !== 1'b0 || bus.ARRANQUE !== 1'b1) $display("FAIL wrong_motor_nocheck: got falla=%b arranque=%b want 0/1", bus.FALLA, bus.ARRANQUE); else n_pass++;
      repeat (3) tick();
      n_total++; if (bus.FALLA !== 1'b1 || bus.CICLOS !== 8'd0) $display("FAIL wrong_motor_timeout: got falla=%b ciclos=%0d want 1/0", bus.FALLA, bus.CICLOS); else n_pass++;
`endif
      bus.MOTOR1 = 1'b0;
   endtask

   task automatic test_reset_async();
      logic [12:0] salidas;
      do_reset();
      pedir(MODO_ELECTRICO);
      bus.MOTOR1 = 1'b1;
      tick();
      repeat (3) tick();
      @(negedge CLK);
      clk_on = 1'b0;
      #2;
      n_total++; if (bus.OCUPADO !== 1'b1 || bus.CICLOS !== 8'd3) $display("FAIL async_pre: got ocupado=%b ciclos=%0d want 1/3", bus.OCUPADO, bus.CICLOS); else n_pass++;
      #3 REINICIO = 1'b1;
      #1;
      salidas = {bus.ARRANQUE, bus.MODO, bus.OCUPADO, bus.LISTO, bus.FALLA, bus.CICLOS};
      n_total++; if (salidas !== 13'd0) $display("FAIL async_reset: got %b want 0", salidas); else n_pass++;
      #5 REINICIO = 1'b0;
      bus.MOTOR1 = 1'b0;
      #5;
      n_total++; if (bus.OCUPADO !== 1'b0) $display("FAIL async_released: got %b want 0", bus.OCUPADO); else n_pass++;
      clk_on = 1'b1;
      pedir(MODO_GAS);
      n_total++; if (bus.ARRANQUE !== 1'b1 || bus.MODO !== 1'b1) $display("FAIL async_new_pedido: got arranque=%b modo=%b want 1/1", bus.ARRANQUE, bus.MODO); else n_pass++;
   endtask

   task automatic test_prioridad();
      do_reset();
      pedir(MODO_ELECTRICO);
      bus.MOTOR1 = 1'b1;
      tick();
      repeat (199) tick();
      n_total++; if (bus.CICLOS !== 8'd199 || bus.FALLA !== 1'b0) $display("FAIL prio_199: got ciclos=%0d falla=%b want 199/0", bus.CICLOS, bus.FALLA); else n_pass++;
      bus.MOTOR2 = 1'b1;
      tick();
      n_total++; if (bus.LISTO !== 1'b1 || bus.FALLA !== 1'b0) $display("FAIL prio_fin_ok: got listo=%b falla=%b want 1/0", bus.LISTO, bus.FALLA); else n_pass++;
      n_total++; if (bus.CICLOS !== 8'd199) $display("FAIL prio_ciclos: got %0d want 199", bus.CICLOS); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_electrico();
      test_gas();
      test_sin_arranque();
      test_protocolo();
      test_reset_async();
      test_prioridad();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mando_vehiculo.md
# mando_vehiculo

Command-side initiator for the hybrid drive controller. It turns a one-cycle user request into the ARRANQUE/MODO start handshake, watches the returned MOTOR1/MOTOR2 lines to confirm the requested mode engaged, and measures how long the drive runs before both motors come on (end of run). It reports success or failure to the supervisory logic. It sits between the operator/supervisor logic and the drive controller, on the opposite end of that controller's ARRANQUE/MODO → MOTOR1/MOTOR2 interface.

## Interface
- `W`, default 8: width of the `CICLOS` run counter. Must satisfy `2^W > T_MARCHA`.
- `T_ARRANQUE`, default 4: number of cycles allowed in ESPERA for the requested motor to engage.
- `T_MARCHA`, default 200: number of cycles allowed in MARCHA before end of run.
- `CLK` in 1: the single clock, rising edge.
- `REINICIO` in 1: reset, asynchronous and active-high. It is the only way out of FIN_OK and FALLA.
- `PEDIDO` in 1: start request. Sampled only in REPOSO.
- `MODO_SEL` in 1: requested mode, sampled together with `PEDIDO`. 1 = gas, 0 = electric.
- `MOTOR1` in 1: electric motor status, from the controller.
- `MOTOR2` in 1: gas motor status, from the controller.
- `ARRANQUE` out 1: start request to the controller.
- `MODO` out 1: latched mode to the controller.
- `OCUPADO` out 1: high in every state except REPOSO.
- `LISTO` out 1: run completed.
- `FALLA` out 1: engage timeout, run timeout, or protocol violation.
- `CICLOS` out W: number of cycles spent in MARCHA.

## Operation
- FSM states: REPOSO, ESPERA, MARCHA, FIN_OK, FALLA. Encoding is one-hot, 5 bits.
- All outputs are Moore outputs, decoded from the state register plus the registered mode and counters.
- Reset values: state = REPOSO; mode register = 0; timeout counter = 0; `CICLOS` = 0. Every output is 0.
- **REPOSO:**
  - If `PEDIDO` = 1: latch `MODO_SEL` into the mode register, clear the timeout counter and `CICLOS`, then go to ESPERA.
  - Otherwise stay in REPOSO.
- **ESPERA:** `ARRANQUE` = 1, `MODO` = mode register, `OCUPADO` = 1. The engage condition depends on the mode:
  - gas mode (1): `MOTOR2` = 1 and `MOTOR1` = 0;
  - electric mode (0): `MOTOR1` = 1 and `MOTOR2` = 0.
  - On each edge:
    - engage condition true → go to MARCHA;
    - else if the timeout counter = `T_ARRANQUE`-1 → go to FALLA;
    - else increment the timeout counter.
- **MARCHA:** `ARRANQUE` = 0, `MODO` = mode register, `OCUPADO` = 1. Each edge is evaluated with this priority:
  1. `MOTOR1` = 1 and `MOTOR2` = 1 → go to FIN_OK. `CICLOS` holds.
  2. Both motors = 0 → go to FALLA (protocol check).
  3. `CICLOS` = `T_MARCHA`-1 → go to FALLA; `CICLOS` becomes `T_MARCHA`.
  4. Otherwise `CICLOS` increments by 1.
- **FIN_OK:** `LISTO` = 1, `OCUPADO` = 1. Terminal state. `PEDIDO` is ignored and `CICLOS` holds.
- **FALLA:** `FALLA` = 1, `OCUPADO` = 1. Terminal state. `PEDIDO` is ignored and `CICLOS` holds.
- Arithmetic: counters are unsigned, and both timeout limits are compared for equality. `CICLOS` never wraps, because the `W` constraint guarantees it.
- An illegal state (not one-hot) goes to REPOSO on the next edge, with all outputs 0 in that cycle.

## Timing
- `PEDIDO` sampled at edge k → `ARRANQUE` is high from k+1.
- With no engage, `ARRANQUE` stays high for exactly `T_ARRANQUE` cycles, then `FALLA` is high from edge k+1+`T_ARRANQUE`.
- Engage seen at edge e → `ARRANQUE` is low from e. `CICLOS` reads 0 in the first MARCHA cycle.
- A `PEDIDO` pulse of any length is accepted once. It is re-sampled only after reset.
- `MODO_SEL` changes after acceptance have no effect.
- `REINICIO` asserted mid-operation → every output is 0 immediately, without waiting for a clock edge. Operation resumes in REPOSO on the first edge after `REINICIO` is released.

## Configuration
- `MANDO_CHEQUEO_EN` defined:
  - the MARCHA protocol check (both motors 0 → FALLA) is present;
  - in ESPERA, the wrong motor alone being on (for example `MOTOR1` in gas mode) → FALLA on that edge.
- `MANDO_CHEQUEO_EN` undefined: both checks are removed, and only the two timeouts can raise `FALLA`.

## Structure
- Shared package `mando_pkg`:
  - the one-hot state constants;
  - the mode constants `MODO_GAS` = 1 and `MODO_ELECTRICO` = 0;
  - the default timeout values.
- Sub-module `contador_limite`: a counter with clear, enable and a "limit reached" compare, parameterised by width and limit. It is instantiated twice, once for the ESPERA timeout and once for `CICLOS`.

## Test plan
- Electric mode, defaults: reset, then `PEDIDO` = 1 with `MODO_SEL` = 0. The model raises `MOTOR1` 2 cycles after `ARRANQUE`, then both motors after 10 cycles.
  - Required: `ARRANQUE` high for 2 cycles, then `LISTO` = 1, `CICLOS` = 10, `FALLA` = 0.
- Gas mode, defaults: the model raises `MOTOR2` only and never both.
  - Required: `FALLA` = 1 after 200 MARCHA cycles, with `CICLOS` = 200 and `LISTO` = 0.
- No engage: `PEDIDO` with `MODO_SEL` = 1 and both motors held at 0.
  - Required: `ARRANQUE` high for exactly 4 cycles, then `FALLA` = 1 and `CICLOS` = 0.
- Protocol check with `MANDO_CHEQUEO_EN` defined: in MARCHA, both motors drop to 0 after 5 cycles.
  - Required: `FALLA` = 1 with `CICLOS` = 5.
- Same protocol stimulus with `MANDO_CHEQUEO_EN` undefined.
  - Required: no fault until `CICLOS` reaches 200.
- Reset and priority:
  - `REINICIO` pulsed in MARCHA while `CLK` is stopped → all outputs 0 asynchronously. A new `PEDIDO` after release is accepted.
  - Both motors = 1 at the same edge as `CICLOS` = 199 → FIN_OK, not FALLA.
